// File: rtl/b_link_pkg.sv
// Shared definitions for the b_initiator / responder-b link.
// Contents: FSM state encoding, vector1 status-byte bit positions,
// address-word field positions and the address-word packing function.
package b_link_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_WDATA = 3'd2,
    ST_TURN  = 3'd3,
    ST_WAIT  = 3'd4,
    ST_RECOV = 3'd5
  } state_t;

  // vector1 status byte from the responder
  localparam int V1_ACK    = 7;
  localparam int V1_ERR    = 6;
  localparam int V1_TAG_HI = 5;
  localparam int V1_TAG_LO = 0;

  // Address word driven on vector2 during the address phase
  localparam int AW_WE      = 15;
  localparam int AW_MARK    = 14;  // always 1: distinguishes an address word
  localparam int AW_TAG_HI  = 13;
  localparam int AW_TAG_LO  = 8;
  localparam int AW_ADDR_HI = 7;
  localparam int AW_ADDR_LO = 0;

  function automatic logic [15:0] pack_addr_word(input logic       we,
                                                 input logic [5:0] tag,
                                                 input logic [7:0] addr);
    logic [15:0] w;
    w                        = '0;
    w[AW_WE]                 = we;
    w[AW_MARK]               = 1'b1;
    w[AW_TAG_HI:AW_TAG_LO]   = tag;
    w[AW_ADDR_HI:AW_ADDR_LO] = addr;
    return w;
  endfunction

endpackage

// File: rtl/b_link_iobuf.sv
// Tristate pad buffer for the shared vector2 bus; isolates the Z-drive from the FSM.
// Latency: combinational; bus follows data_out/oe directly, data_in mirrors the bus.
// Backpressure: none. Ports: data_out/oe (drive side), bus (inout), data_in (sense side).
module b_link_iobuf #(
  parameter int W = 16
) (
  input  logic [W-1:0] data_out,
  input  logic         oe,
  inout  wire  [W-1:0] bus,
  output logic [W-1:0] data_in
);

  assign bus     = oe ? data_out : {W{1'bz}};
  assign data_in = bus;

endmodule

// File: rtl/b_initiator.sv
// Initiator for the vector1/vector2 link: runs single-word local requests on the shared bus.
// Latency: request-to-response >= 4 cycles (ack in first WAIT cycle); timeout response at accept+3+TIMEOUT.
// Backpressure: req_ready high only in IDLE; one request in flight. Ports: req_* local request,
// rsp_* one-cycle response strobe, vector1 responder status, vector2 shared bidirectional bus.
module b_initiator
  import b_link_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [7:0]  req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  input  logic [7:0]  vector1,
  inout  wire  [15:0] vector2
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [5:0]    tag_q;
  logic [CW-1:0] wait_cnt_q;
  logic          we_q;
  logic [15:0]   wdata_q;
  logic [15:0]   bus_out_q, bus_out_d;
  logic          bus_oe_q, bus_oe_d;
  logic [15:0]   bus_in;
  logic          req_ready_q, rsp_valid_q, rsp_err_q, rsp_err_d;
  logic [15:0]   rsp_rdata_q, rsp_rdata_d;

  logic accept, ack_match, timeout_hit, finishing;

  assign accept      = req_valid && req_ready_q;
  assign ack_match   = vector1[V1_ACK] && (vector1[V1_TAG_HI:V1_TAG_LO] == tag_q);
  assign timeout_hit = (wait_cnt_q == CNT_LAST);
  assign finishing   = (state_q == ST_WAIT) && (state_d == ST_RECOV);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    bus_oe_d    = 1'b0;
    bus_out_d   = '0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_ADDR;
      ST_ADDR:  state_d = we_q ? ST_WDATA : ST_TURN;
      ST_WDATA: state_d = ST_WAIT;
      ST_TURN:  state_d = ST_WAIT;
      // A matching ack in the last allowed cycle takes priority over the timeout
      ST_WAIT:  if (ack_match || timeout_hit) state_d = ST_RECOV;
      ST_RECOV: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Bus drive is registered: compute what the next state needs on the wire.
    // The address word comes straight from the request inputs, since ADDR is
    // only ever entered from the accepting IDLE cycle.
    if (state_d == ST_ADDR) begin
      bus_oe_d  = 1'b1;
      bus_out_d = pack_addr_word(req_we, tag_q, req_addr);
    end else if (state_d == ST_WDATA) begin
      bus_oe_d  = 1'b1;
      bus_out_d = wdata_q;
    end

    if (finishing) begin
      if (ack_match) begin
        rsp_err_d = vector1[V1_ERR];
        if (!we_q && !vector1[V1_ERR]) rsp_rdata_d = bus_in;
      end else begin
        rsp_err_d = 1'b1;  // timeout
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q       <= '0;
      wait_cnt_q  <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      bus_out_q   <= '0;
      bus_oe_q    <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      req_ready_q <= (state_d == ST_IDLE);
      rsp_valid_q <= (state_d == ST_RECOV);
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      bus_oe_q    <= bus_oe_d;
      bus_out_q   <= bus_out_d;
      if (accept) begin
        we_q    <= req_we;
        wdata_q <= req_wdata;
      end
      // Counter is zero on WAIT entry and counts completed WAIT cycles
      wait_cnt_q <= (state_q == ST_WAIT) ? wait_cnt_q + CW'(1) : '0;
      if (state_q == ST_RECOV) tag_q <= tag_q + 6'd1;
    end
  end

  b_link_iobuf #(.W(16)) u_iobuf (
    .data_out (bus_out_q),
    .oe       (bus_oe_q),
    .bus      (vector2),
    .data_in  (bus_in)
  );

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_b_initiator.sv
// Directed self-checking bench for b_initiator; a released vector2 bus reads as all ones (pull-up).
module tb_b_initiator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [7:0]  req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic [7:0]  vector1 = '0;
  logic        tb_oe = 1'b0;
  logic [15:0] tb_dat = '0;
  wire         req_ready, rsp_valid, rsp_err;
  wire  [15:0] rsp_rdata;
  wire  [15:0] vector2;

  int n_checks = 0;
  int n_fail   = 0;

  assign vector2 = tb_oe ? tb_dat : 16'hzzzz;
  pullup (vector2);

  always #5 clk = ~clk;

  b_initiator #(.TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .vector1(vector1), .vector2(vector2)
  );

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err got %b want 0", rsp_err); end
    n_checks++; if (rsp_rdata !== 16'h0000) begin n_fail++; $display("FAIL reset_rsp_rdata got %h want 0000", rsp_rdata); end
    n_checks++; if (vector2 !== 16'hFFFF) begin n_fail++; $display("FAIL reset_bus_released got %h want ffff", vector2); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Write 0x5A <- 0xBEEF, tag 0, ack in first WAIT cycle
  task automatic test_write();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h5A; req_wdata = 16'hBEEF;
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL wr_ready_idle got %b want 1", req_ready); end
    @(posedge clk); #1 req_valid = 1'b0;                     // N+1
    @(negedge clk);
    n_checks++; if (vector2 !== 16'hC05A) begin n_fail++; $display("FAIL wr_addr_word got %h want c05a", vector2); end
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL wr_ready_busy got %b want 0", req_ready); end
    @(posedge clk); @(negedge clk);                          // N+2
    n_checks++; if (vector2 !== 16'hBEEF) begin n_fail++; $display("FAIL wr_data_word got %h want beef", vector2); end
    @(posedge clk); #1 vector1 = 8'h80;                      // N+3 ack tag 0
    @(negedge clk);
    n_checks++; if (vector2 !== 16'hFFFF) begin n_fail++; $display("FAIL wr_wait_released got %h want ffff", vector2); end
    @(posedge clk); #1 vector1 = 8'h00;                      // N+4
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL wr_rsp_valid got %b want 1", rsp_valid); end
    n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL wr_rsp_err got %b want 0", rsp_err); end
    n_checks++; if (rsp_rdata !== 16'h0000) begin n_fail++; $display("FAIL wr_rsp_rdata got %h want 0000", rsp_rdata); end
    @(posedge clk); @(negedge clk);                          // N+5
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_rsp_one_cycle got %b want 0", rsp_valid); end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL wr_ready_again got %b want 1", req_ready); end
    @(posedge clk); #1;
  endtask

  // Read 0x12, tag 1; stale tag-0 ack at N+3 ignored, real ack at N+5
  task automatic test_read_stale();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h12;
    @(posedge clk); #1 req_valid = 1'b0;                     // N+1
    @(negedge clk);
    n_checks++; if (vector2 !== 16'h4112) begin n_fail++; $display("FAIL rd_addr_word got %h want 4112", vector2); end
    @(posedge clk); @(negedge clk);                          // N+2 TURN
    n_checks++; if (vector2 !== 16'hFFFF) begin n_fail++; $display("FAIL rd_turn_released got %h want ffff", vector2); end
    @(posedge clk); #1 vector1 = 8'h80;                      // N+3 stale tag 0
    @(posedge clk); #1 vector1 = 8'h00;                      // N+4
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rd_stale_ignored got %b want 0", rsp_valid); end
    @(posedge clk); #1 vector1 = 8'h81; tb_oe = 1'b1; tb_dat = 16'h1234;  // N+5
    @(posedge clk); #1 vector1 = 8'h00; tb_oe = 1'b0;        // N+6
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rd_rsp_valid got %b want 1", rsp_valid); end
    n_checks++; if (rsp_rdata !== 16'h1234) begin n_fail++; $display("FAIL rd_rsp_rdata got %h want 1234", rsp_rdata); end
    n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL rd_rsp_err got %b want 0", rsp_err); end
    n_checks++; if (vector2 !== 16'hFFFF) begin n_fail++; $display("FAIL rd_recov_released got %h want ffff", vector2); end
    @(posedge clk); @(negedge clk);                          // N+7
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rd_ready_again got %b want 1", req_ready); end
    @(posedge clk); #1;
  endtask

  // Read tag 2, never acked: ack during ADDR and wrong-tag ack are ignored
  task automatic test_timeout();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h33;
    @(posedge clk); #1 req_valid = 1'b0; vector1 = 8'h82;    // N+1 ack in ADDR
    @(posedge clk); #1 vector1 = 8'h00;                      // N+2
    repeat (8) @(posedge clk);                               // N+10
    #1 vector1 = 8'hC1;                                      // wrong tag
    @(posedge clk); #1 vector1 = 8'h00;                      // N+11
    repeat (6) @(posedge clk);                               // N+17
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL to_early got %b want 0", rsp_valid); end
    @(posedge clk); @(negedge clk);                          // N+18
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL to_rsp_valid got %b want 1", rsp_valid); end
    n_checks++; if (rsp_err !== 1'b1) begin n_fail++; $display("FAIL to_rsp_err got %b want 1", rsp_err); end
    n_checks++; if (rsp_rdata !== 16'h0000) begin n_fail++; $display("FAIL to_rsp_rdata got %h want 0000", rsp_rdata); end
    @(posedge clk); @(negedge clk);                          // N+19
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL to_ready_again got %b want 1", req_ready); end
    @(posedge clk); #1;
  endtask

  // Read tag 3, ack in the last allowed WAIT cycle (N+17) beats the timeout
  task automatic test_last_cycle_ack();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h44;
    @(posedge clk); #1 req_valid = 1'b0;                     // N+1
    repeat (16) @(posedge clk);                              // N+17
    #1 vector1 = 8'h83; tb_oe = 1'b1; tb_dat = 16'h0F0F;
    @(posedge clk); #1 vector1 = 8'h00; tb_oe = 1'b0;        // N+18
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL last_rsp_valid got %b want 1", rsp_valid); end
    n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL last_rsp_err got %b want 0", rsp_err); end
    n_checks++; if (rsp_rdata !== 16'h0F0F) begin n_fail++; $display("FAIL last_rsp_rdata got %h want 0f0f", rsp_rdata); end
    @(posedge clk); #1;
  endtask

  // 64 writes issued as soon as req_ready returns; tag wraps 63->0
  task automatic test_back_to_back();
    logic [5:0]  exp_tag;
    logic        err;
    logic [15:0] exp_word;
    exp_tag = 6'd4;
    for (int i = 0; i < 64; i++) begin
      err = (exp_tag == 6'd63) || (i == 63);
      exp_word = {2'b11, exp_tag, 8'(i)};
      req_valid = 1'b1; req_we = 1'b1; req_addr = 8'(i); req_wdata = 16'(i * 3);
      @(negedge clk);
      n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d] got %b want 1", i, req_ready); end
      @(posedge clk); #1 req_valid = 1'b0;                   // N+1
      @(negedge clk);
      n_checks++; if (vector2 !== exp_word) begin n_fail++; $display("FAIL b2b_addr_word[%0d] got %h want %h", i, vector2, exp_word); end
      @(posedge clk); @(posedge clk);                        // N+3
      #1 vector1 = {1'b1, err, exp_tag};
      @(posedge clk); #1 vector1 = 8'h00;                    // N+4
      @(negedge clk);
      n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_rsp_valid[%0d] got %b want 1", i, rsp_valid); end
      n_checks++; if (rsp_err !== err) begin n_fail++; $display("FAIL b2b_rsp_err[%0d] got %b want %b", i, rsp_err, err); end
      @(posedge clk); #1;                                    // N+5
      exp_tag = exp_tag + 6'd1;
    end
  endtask

  // Reset during WDATA: bus released at once, no response, tag back to 0
  task automatic test_reset_midflight();
    int seen;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h77; req_wdata = 16'hA5A5;
    @(posedge clk); #1 req_valid = 1'b0;                     // N+1
    @(posedge clk); @(negedge clk);                          // N+2 WDATA
    n_checks++; if (vector2 !== 16'hA5A5) begin n_fail++; $display("FAIL rst_wdata_driven got %h want a5a5", vector2); end
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (vector2 !== 16'hFFFF) begin n_fail++; $display("FAIL rst_bus_released got %h want ffff", vector2); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid got %b want 0", rsp_valid); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) seen++;
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL rst_no_response got %0d strobes want 0", seen); end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b want 1", req_ready); end
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h01;
    @(posedge clk); #1 req_valid = 1'b0;                     // N+1
    @(negedge clk);
    n_checks++; if (vector2 !== 16'h4001) begin n_fail++; $display("FAIL rst_tag_zero got %h want 4001", vector2); end
    @(posedge clk); @(posedge clk);                          // N+3
    #1 vector1 = 8'h80; tb_oe = 1'b1; tb_dat = 16'h5555;
    @(posedge clk); #1 vector1 = 8'h00; tb_oe = 1'b0;        // N+4
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rst_after_rsp_valid got %b want 1", rsp_valid); end
    n_checks++; if (rsp_rdata !== 16'h5555) begin n_fail++; $display("FAIL rst_after_rdata got %h want 5555", rsp_rdata); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_stale();
    test_timeout();
    test_last_cycle_ack();
    test_back_to_back();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
